row_clear_engine: RTL

ROW_CLEAR_ENGINE -- requirements
Module: row_clear_engine

---
 rtl/row_clear_engine_pkg.sv | 39 +++
 rtl/row_clear_engine_row_shifter.sv | 45 ++++
 rtl/row_clear_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/row_clear_engine_pkg.sv
// ---------------------------------------------------------------------------
// row_clear_engine_pkg
// Shared definitions for the row clear engine: board geometry, row pointer
// width, FSM state encoding and the score increment table.
// Optional feature macro: ROW_CLEAR_SCORE_EN (adds a saturating score output).
// ---------------------------------------------------------------------------
package row_clear_engine_pkg;

  localparam int BLOCKS_WIDE  = 10;
  localparam int BLOCKS_HIGH  = 20;
  localparam int BOARD_BITS   = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam int BITS_ROW_IDX = 5;
  localparam int CLEARED_BITS = 5;
  localparam int SCORE_BITS   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Points awarded for clearing k rows in one run; k of four or more
  // all earn the same top award.
  function automatic logic [SCORE_BITS-1:0] scoreIncrement(
    input logic [CLEARED_BITS-1:0] k
  );
    logic [SCORE_BITS-1:0] inc;
    case (k)
      5'd0:    inc = 16'd0;
      5'd1:    inc = 16'd1;
      5'd2:    inc = 16'd3;
      5'd3:    inc = 16'd5;
      default: inc = 16'd8;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/row_clear_engine_row_shifter.sv
// ---------------------------------------------------------------------------
// row_shifter
// Purely combinational helper for the row clear engine. It reports whether
// the row selected by the pointer is completely filled, and produces the
// board as it would look with that row removed: every row above the pointer
// drops down by one, the top row becomes empty, rows below stay put.
// Ports:
//   board         - current board bitmap, bit index = x + y*BLOCKS_WIDE
//   pointer       - row under test (0 = top row)
//   row_full      - all BLOCKS_WIDE bits of the pointed row are set
//   shifted_board - board with the pointed row removed
// ---------------------------------------------------------------------------
module row_shifter
  import row_clear_engine_pkg::*;
(
  input  logic [BOARD_BITS-1:0]   board,
  input  logic [BITS_ROW_IDX-1:0] pointer,
  output logic                    row_full,
  output logic [BOARD_BITS-1:0]   shifted_board
);

  // Row select is a constant-slice loop so an out-of-range pointer simply
  // reads as "not full" instead of indexing past the board.
  always_comb begin
    row_full = 1'b0;
    for (int r = 0; r < BLOCKS_HIGH; r++) begin
      if (pointer == BITS_ROW_IDX'(r)) begin
        row_full = &board[r*BLOCKS_WIDE +: BLOCKS_WIDE];
      end
    end
  end

  // Row 0 is always at or above the pointer, so it is always emptied.
  always_comb begin
    shifted_board = board;
    shifted_board[0 +: BLOCKS_WIDE] = '0;
    for (int r = 1; r < BLOCKS_HIGH; r++) begin
      if (BITS_ROW_IDX'(r) <= pointer) begin
        shifted_board[r*BLOCKS_WIDE +: BLOCKS_WIDE] =
          board[(r-1)*BLOCKS_WIDE +: BLOCKS_WIDE];
      end
    end
  end

endmodule

// File: rtl/row_clear_engine.sv
// ---------------------------------------------------------------------------
// row_clear_engine
// Removes completed rows from a settled-block bitmap. On an accepted start
// the board is latched, then scanned from the bottom row upward. A full row
// is removed (everything above drops one row) and the same row index is
// tested again, since a new row has just fallen into it.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   start        - begin processing board_in (only honoured in IDLE)
//   board_in     - settled-block bitmap, bit index = x + y*BLOCKS_WIDE
//   board_out    - compacted bitmap, held until the next accepted start
//   busy         - high in every state except IDLE
//   done         - one-cycle completion pulse
//   rows_cleared - number of rows removed in the last run
//   score        - (only with ROW_CLEAR_SCORE_EN) saturating running score
// Optional feature macro: ROW_CLEAR_SCORE_EN
// ---------------------------------------------------------------------------
module row_clear_engine
  import row_clear_engine_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BOARD_BITS-1:0]   board_in,
  output logic [BOARD_BITS-1:0]   board_out,
  output logic                    busy,
  output logic                    done,
  output logic [CLEARED_BITS-1:0] rows_cleared
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [SCORE_BITS-1:0]   score
`endif
);

  localparam logic [BITS_ROW_IDX-1:0] LAST_ROW = BITS_ROW_IDX'(BLOCKS_HIGH - 1);

  state_t                  state_q, state_d;
  logic [BITS_ROW_IDX-1:0] ptr_q, ptr_d;
  logic [BOARD_BITS-1:0]   board_q, board_d;
  logic [CLEARED_BITS-1:0] cleared_q, cleared_d;

  logic                    rowFull;
  logic [BOARD_BITS-1:0]   shiftedBoard;

  row_shifter u_row_shifter (
    .board         (board_q),
    .pointer       (ptr_q),
    .row_full      (rowFull),
    .shifted_board (shiftedBoard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      board_q   <= '0;
      cleared_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      board_q   <= board_d;
      cleared_q <= cleared_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    board_d   = board_q;
    cleared_d = cleared_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          board_d   = board_in;
          cleared_d = '0;
          ptr_d     = LAST_ROW;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (rowFull) begin
          state_d = SHIFT;
        end else if (ptr_q == '0) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      SHIFT: begin
        board_d = shiftedBoard;
        // The counter cannot reach all-ones with the current geometry; the
        // guard keeps it from wrapping if the board is ever made taller.
        if (cleared_q != '1) begin
          cleared_d = cleared_q + 1'b1;
        end
        state_d = SCAN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign board_out    = board_q;
  assign rows_cleared = cleared_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

`ifdef ROW_CLEAR_SCORE_EN
  logic [SCORE_BITS-1:0] score_q, score_d;
  logic [SCORE_BITS:0]   scoreSum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  // The extra carry bit of the sum tells us when to pin at the maximum.
  always_comb begin
    scoreSum = {1'b0, score_q} + {1'b0, scoreIncrement(cleared_q)};
    score_d  = score_q;
    if (state_q == DONE) begin
      score_d = scoreSum[SCORE_BITS] ? '1 : scoreSum[SCORE_BITS-1:0];
    end
  end

  assign score = score_q;
`endif

endmodule
